// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : Single-outstanding command/response front end driving an APB
//            requester. Optional ACCESS timeout via APB_CMD_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e      state_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;
    logic [2:0]  pprot_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_slverr_q;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_timeout_q;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'd0;
            pwdata_q      <= 32'd0;
            pstrb_q       <= 4'd0;
            pprot_q       <= 3'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_slverr_q  <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_wdata;
                        // Reads never carry byte strobes on the bus.
                        pstrb_q   <= cmd_write ? cmd_strb : 4'b0000;
                        pprot_q   <= cmd_prot;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state_q      <= RESP;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_slverr_q <= pslverr;
                        rsp_rdata_q  <= pwrite_q ? 32'd0 : prdata;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
                    end else if (wait_cnt_q == CNT_LIMIT) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_slverr_q  <= 1'b1;
                        rsp_rdata_q   <= 32'd0;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign pprot      = pprot_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    // Timeout compiled out: ACCESS waits for pready indefinitely.
    logic w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign rsp_timeout             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Purpose  : Directed scoreboard bench for apb_cmd_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int TMO = 8;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed response, expected none (scoreboard empty)", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdata"},  rsp_rdata,   e.rdata);
            chk({tag, "_slverr"}, rsp_slverr,  e.slverr);
            chk({tag, "_tmo"},    rsp_timeout, e.tmo);
        end
    endtask

    // Issues one command from IDLE and checks the resulting SETUP cycle.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] erd, input logic eerr, input logic etmo,
                        input logic push);
        exp_t e;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_strb  = strb;
        cmd_prot  = prot;
        cmd_valid = 1'b1;
        if (push) begin
            e.rdata  = erd;
            e.slverr = eerr;
            e.tmo    = etmo;
            sb.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
        chk("setup_psel",    psel,    1);
        chk("setup_penable", penable, 0);
        chk("setup_cmd_rdy", cmd_ready, 0);
        chk("setup_paddr",   paddr,   addr);
        chk("setup_pwrite",  pwrite,  wr);
        chk("setup_pstrb",   pstrb,   wr ? strb : 4'b0000);
        chk("setup_pprot",   pprot,   prot);
        if (wr) chk("setup_pwdata", pwdata, data);
    endtask

    initial begin
        int   hi;
        int   gap;
        logic found;
        logic stuck_ok;

        preset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        cmd_strb  = 4'd0;
        cmd_prot  = 3'd0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'd0;

        // Asynchronous reset: outputs must clear before any clock edge.
        #1 preset = 1'b1;
        #1;
        chk("rst_psel",    psel,        0);
        chk("rst_penable", penable,     0);
        chk("rst_pwrite",  pwrite,      0);
        chk("rst_paddr",   paddr,       0);
        chk("rst_pwdata",  pwdata,      0);
        chk("rst_pstrb",   pstrb,       0);
        chk("rst_pprot",   pprot,       0);
        chk("rst_rvalid",  rsp_valid,   0);
        chk("rst_rdata",   rsp_rdata,   0);
        chk("rst_slverr",  rsp_slverr,  0);
        chk("rst_tmo",     rsp_timeout, 0);
        step();
        step();
        preset = 1'b0;
        step();
        chk("rel_cmd_ready", cmd_ready, 1);

        // Write, immediate pready (high even before ACCESS, must be ignored).
        pready = 1'b1;
        send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("w_acc_psel",    psel,    1);
        chk("w_acc_penable", penable, 1);
        step();
        chk("w_rsp_valid",   rsp_valid, 1);
        chk("w_rsp_psel",    psel,      0);
        chk("w_rsp_penable", penable,   0);
        pop_cmp("w_rsp");
        step();
        chk("w_idle_valid",  rsp_valid, 0);
        chk("w_idle_ready",  cmd_ready, 1);

        // Read with three wait states.
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        send(1'b0, 32'h4000_0020, 32'h0, 4'hF, 3'b000, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (penable === 1'b1) hi++;
            chk("r_acc_paddr", paddr, 32'h4000_0020);
            chk("r_acc_pstrb", pstrb, 0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
        end
        chk("r_penable_cycles", hi, 4);
        step();
        pready = 1'b0;
        prdata = 32'h0;
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_penable", penable, 0);
        pop_cmp("r_rsp");
        step();

        // Write error with response backpressure; cmd_* must be ignored meanwhile.
        pready    = 1'b1;
        pslverr   = 1'b1;
        rsp_ready = 1'b0;
        send(1'b1, 32'h4000_0030, 32'hA5A5_5A5A, 4'h3, 3'b001, 32'd0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        chk("werr_rsp_valid", rsp_valid, 1);
        pop_cmp("werr_rsp");
        pslverr   = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h9999_9999;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("werr_hold_valid",  rsp_valid,  1);
            chk("werr_hold_ready",  cmd_ready,  0);
            chk("werr_hold_slverr", rsp_slverr, 1);
            chk("werr_hold_paddr",  paddr,      32'h4000_0030);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("werr_idle_valid", rsp_valid, 0);

        // Read error still returns the captured prdata.
        pslverr = 1'b1;
        prdata  = 32'hCAFE_F00D;
        send(1'b0, 32'h4000_0040, 32'h0, 4'hF, 3'b000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
        step();
        step();
        chk("rerr_rsp_valid", rsp_valid, 1);
        pop_cmp("rerr_rsp");
        pslverr = 1'b0;
        prdata  = 32'h0;
        step();

        // Back-to-back: second SETUP four cycles after the first.
        send(1'b1, 32'h5000_0000, 32'h1111_1111, 4'hF, 3'b000, 32'd0, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h5000_0004;
        cmd_wdata = 32'h2222_2222;
        sb.push_back('{rdata: 32'd0, slverr: 1'b0, tmo: 1'b0});
        gap   = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            step();
            if (rsp_valid === 1'b1) pop_cmp("b2b_a_rsp");
            if (psel === 1'b1 && penable === 1'b0) begin
                gap   = i;
                found = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_gap", gap, 4);
        chk("b2b_paddr", paddr, 32'h5000_0004);
        step();
        step();
        chk("b2b_b_valid", rsp_valid, 1);
        pop_cmp("b2b_b_rsp");
        step();

        // pready stuck low.
        pready = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        send(1'b0, 32'h4000_0050, 32'h0, 4'hF, 3'b000, 32'd0, 1'b1, 1'b1, 1'b1);
        hi = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            step();
            if (penable === 1'b1) hi++;
        end
        chk("tmo_access_cycles", hi, TMO + 1);
        step();
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_psel", psel, 0);
        pop_cmp("tmo_rsp");
        step();
        send(1'b0, 32'h4000_0058, 32'h0, 4'hF, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
`else
        send(1'b0, 32'h4000_0050, 32'h0, 4'hF, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0);
        stuck_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!(penable === 1'b1 && psel === 1'b1 && rsp_valid === 1'b0)) stuck_ok = 1'b0;
        end
        chk("stuck_no_timeout", stuck_ok, 1);
`endif

        // Reset in the middle of ACCESS abandons the transfer.
        chk("mid_penable_pre", penable, 1);
        preset = 1'b1;
        #1;
        chk("mid_rst_psel",    psel,    0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_valid",   rsp_valid, 0);
        step();
        step();
        preset = 1'b0;
        step();
        chk("mid_rel_valid", rsp_valid, 0);
        chk("mid_rel_ready", cmd_ready, 1);
        pready = 1'b1;
        send(1'b1, 32'h4000_0060, 32'h0BAD_CAFE, 4'hC, 3'b100, 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("post_rst_valid", rsp_valid, 1);
        pop_cmp("post_rst_rsp");
        step();
        chk("post_rst_idle", rsp_valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
